// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// Read misses stall for MISS_PENALTY wait cycles plus one refill cycle; stores go straight to memory.
module dcache_dm #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int WORD_WIDTH    = 32,
  parameter int SETS          = 256,
  parameter int MISS_PENALTY  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] cpu_A,
  input  logic [WORD_WIDTH-1:0]    cpu_WD,
  input  logic                     cpu_WE,
  input  logic                     cpu_RE,
  output logic [WORD_WIDTH-1:0]    cpu_RD,
  output logic                     stall,
  output logic [ADDRESS_WIDTH-1:0] mem_A,
  output logic [WORD_WIDTH-1:0]    mem_WD,
  output logic                     mem_WE,
  input  logic [WORD_WIDTH-1:0]    mem_RD,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = ADDRESS_WIDTH - 2 - IW;
  localparam int CW = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_MISS_WAIT = 2'd1;
  localparam logic [1:0] S_FILL      = 2'd2;

  logic [1:0]               state_q;
  logic [CW-1:0]            wait_q;
  logic                     replay_q;
  logic [ADDRESS_WIDTH-1:0] miss_addr_q;
  logic [SETS-1:0]          valid_q;
  logic [TW-1:0]            tag_q  [SETS];
  logic [WORD_WIDTH-1:0]    data_q [SETS];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;
  logic          hit;
  logic          idle;
  logic          do_store;
  logic          do_load;

  assign idx      = cpu_A[IW+1:2];
  assign tag      = cpu_A[ADDRESS_WIDTH-1:IW+2];
  assign miss_idx = miss_addr_q[IW+1:2];
  assign miss_tag = miss_addr_q[ADDRESS_WIDTH-1:IW+2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign idle     = (state_q == S_IDLE);
  // A simultaneous store and load is treated purely as a store.
  assign do_store = idle && cpu_WE;
  assign do_load  = idle && cpu_RE && !cpu_WE;

  // Outputs are forced quiet while reset is asserted, independent of the clock.
  always_comb begin
    cpu_RD = '0;
    stall  = 1'b0;
    mem_A  = cpu_A;
    mem_WD = cpu_WD;
    mem_WE = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cpu_WE) begin
          mem_WE = 1'b1;
        end else if (cpu_RE) begin
          if (hit) cpu_RD = data_q[idx];
          else     stall  = 1'b1;
        end
      end
      S_MISS_WAIT, S_FILL: begin
        stall = 1'b1;
        mem_A = miss_addr_q;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
    if (!rst_n) begin
      cpu_RD = '0;
      stall  = 1'b0;
      mem_A  = '0;
      mem_WD = '0;
      mem_WE = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      replay_q    <= 1'b0;
      miss_addr_q <= '0;
      valid_q     <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          replay_q <= 1'b0;
          if (do_load) begin
            if (hit) begin
              if (!replay_q) hit_count <= hit_count + 32'd1;
            end else begin
              state_q     <= S_MISS_WAIT;
              wait_q      <= CW'(MISS_PENALTY - 1);
              miss_count  <= miss_count + 32'd1;
              miss_addr_q <= {cpu_A[ADDRESS_WIDTH-1:2], 2'b00};
            end
          end
        end
        S_MISS_WAIT: begin
          if (wait_q == '0) state_q <= S_FILL;
          else              wait_q  <= wait_q - CW'(1);
        end
        S_FILL: begin
          valid_q[miss_idx] <= 1'b1;
          replay_q          <= 1'b1;
          state_q           <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid_q alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (do_store && hit) begin
        data_q[idx] <= cpu_WD;
      end else if (state_q == S_FILL) begin
        data_q[miss_idx] <= mem_RD;
        tag_q[miss_idx]  <= miss_tag;
      end
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: a small word memory model answers mem_A and
// records stores; expected values are written out by hand.
module tb_dcache_dm;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_A;
  logic [31:0] cpu_WD;
  logic        cpu_WE;
  logic        cpu_RE;
  logic [31:0] cpu_RD;
  logic        stall;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_arr [0:1023];

  dcache_dm #(
    .ADDRESS_WIDTH(32), .WORD_WIDTH(32), .SETS(256), .MISS_PENALTY(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_A(cpu_A), .cpu_WD(cpu_WD), .cpu_WE(cpu_WE),
    .cpu_RE(cpu_RE), .cpu_RD(cpu_RD), .stall(stall), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_WE(mem_WE), .mem_RD(mem_RD), .hit_count(hit_count), .miss_count(miss_count)
  );

  // clock / reset-free memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'hC0DE_0000 | i;
  end

  assign mem_RD = mem_arr[mem_A[11:2]];

  always @(posedge clk) begin
    if (mem_WE) mem_arr[mem_A[11:2]] <= mem_WD;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    cpu_A  = '0;
    cpu_WD = '0;
    cpu_WE = 1'b0;
    cpu_RE = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue a load, count the stall cycles, and check the returned word.
  task automatic do_load(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input int exp_stalls);
    int n;
    @(negedge clk);
    cpu_A  = addr;
    cpu_RE = 1'b1;
    cpu_WE = 1'b0;
    #1;
    n = 0;
    while (stall && n < 50) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stalls"}, 32'(n), 32'(exp_stalls));
    check({tag, "_data"}, cpu_RD, exp_data);
    @(negedge clk);
    cpu_RE = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    cpu_A  = addr;
    cpu_WD = data;
    cpu_WE = 1'b1;
    cpu_RE = 1'b0;
    #1;
    check({tag, "_we"}, 32'(mem_WE), 32'd1);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_mem_a"}, mem_A, addr);
    check({tag, "_mem_wd"}, mem_WD, data);
    @(negedge clk);
    cpu_WE = 1'b0;
    #1;
    check({tag, "_we_drop"}, 32'(mem_WE), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    cpu_A  = 32'h0000_1234;
    cpu_WD = 32'hFFFF_FFFF;
    cpu_WE = 1'b0;
    cpu_RE = 1'b1;
    #12;
    // outputs forced quiet during reset even with a request present
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_we", 32'(mem_WE), 32'd0);
    check("rst_cpu_rd", cpu_RD, 32'd0);
    check("rst_mem_a", mem_A, 32'd0);
    check("rst_mem_wd", mem_WD, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    do_reset();

    #1;
    check("idle_rd", cpu_RD, 32'd0);
    check("idle_mem_a", mem_A, 32'd0);

    do_load("miss1", 32'h0001_0000, 32'hC0DE_0000, 6);
    check("miss1_misses", miss_count, 32'd1);
    check("miss1_hits", hit_count, 32'd0);

    do_load("hit1", 32'h0001_0000, 32'hC0DE_0000, 0);
    check("hit1_hits", hit_count, 32'd1);
    check("hit1_misses", miss_count, 32'd1);

    do_store("st_res", 32'h0001_0000, 32'hDEAD_BEEF);
    check("st_res_mem", mem_arr[0], 32'hDEAD_BEEF);
    do_load("hit2", 32'h0001_0000, 32'hDEAD_BEEF, 0);
    check("hit2_hits", hit_count, 32'd2);

    // store with load asserted: store only, no read, counters untouched
    @(negedge clk);
    cpu_A  = 32'h0001_0000;
    cpu_WD = 32'hA5A5_5A5A;
    cpu_WE = 1'b1;
    cpu_RE = 1'b1;
    #1;
    check("stld_we", 32'(mem_WE), 32'd1);
    check("stld_rd", cpu_RD, 32'd0);
    check("stld_stall", 32'(stall), 32'd0);
    @(negedge clk);
    cpu_WE = 1'b0;
    cpu_RE = 1'b0;
    check("stld_hits", hit_count, 32'd2);
    check("stld_misses", miss_count, 32'd1);
    do_load("hit3", 32'h0001_0000, 32'hA5A5_5A5A, 0);

    do_store("st_nonres", 32'h0001_0400, 32'h1234_5678);
    do_load("hit_after_nr", 32'h0001_0000, 32'hA5A5_5A5A, 0);
    check("nr_no_evict_hits", hit_count, 32'd4);
    do_load("miss2", 32'h0001_0400, 32'h1234_5678, 6);
    check("miss2_misses", miss_count, 32'd2);

    // reset during the third MISS_WAIT cycle
    @(negedge clk);
    cpu_A  = 32'h0001_0000;
    cpu_RE = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mid_pre_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_stall", 32'(stall), 32'd0);
    check("mid_hits", hit_count, 32'd0);
    check("mid_misses", miss_count, 32'd0);
    cpu_RE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_load("mid_reload", 32'h0001_0000, 32'hA5A5_5A5A, 6);
    check("mid_reload_misses", miss_count, 32'd1);

    // aliasing from a fresh reset
    do_reset();
    do_load("al_a", 32'h0001_0000, 32'hA5A5_5A5A, 6);
    do_load("al_b", 32'h0001_0400, 32'h1234_5678, 6);
    do_load("al_c", 32'h0001_0000, 32'hA5A5_5A5A, 6);
    check("al_misses", miss_count, 32'd3);
    check("al_hits", hit_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_dm.md
# dcache_dm

Direct-mapped, write-through, no-write-allocate data cache in the memory stage, between the pipeline's load/store path and the byte-addressed data memory. It serves read hits combinationally with no stall. Read misses are handled by a miss FSM that waits a programmable penalty, then refills the line from data memory while stalling the pipeline. It also keeps read hit/miss performance counters.

## Interface

Parameters:
- ADDRESS_WIDTH, 32, byte-address width
- WORD_WIDTH, 32, data word width
- SETS, 256, number of lines (one word per line); power of two
- MISS_PENALTY, 4, modelled backing-memory wait in cycles; ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_A  in  ADDRESS_WIDTH  load/store byte address; word-aligned, A[1:0] ignored
- cpu_WD  in  WORD_WIDTH  store data
- cpu_WE  in  1  store request
- cpu_RE  in  1  load request
- cpu_RD  out  WORD_WIDTH  load data
- stall  out  1  pipeline hold request
- mem_A  out  ADDRESS_WIDTH  data memory address
- mem_WD  out  WORD_WIDTH  data memory write data
- mem_WE  out  1  data memory write enable
- mem_RD  in  WORD_WIDTH  data memory read data, combinational in mem_A
- hit_count  out  32  read hits, excluding refill replays
- miss_count  out  32  read misses

## Operation

- Address split:
  - index = cpu_A[2+log2(SETS)-1:2]
  - tag = cpu_A[ADDRESS_WIDTH-1:2+log2(SETS)]
- Per line: valid bit, tag, data word.
- FSM states: IDLE, MISS_WAIT, FILL.
- IDLE, cpu_WE=1 (store):
  - mem_A=cpu_A, mem_WD=cpu_WD, mem_WE=1; stall=0.
  - On tag hit, the line data is also updated at the clock edge.
  - On miss, no allocate; line unchanged.
- IDLE, cpu_WE=1 with cpu_RE=1: treated as a store only; no read, no counter change.
- IDLE, cpu_RE=1, hit (valid and tag match):
  - cpu_RD = line data, stall=0.
  - hit_count += 1 unless the replay flag is set.
- IDLE, cpu_RE=1, miss:
  - stall=1 combinationally.
  - Next state MISS_WAIT, wait counter = MISS_PENALTY-1, miss_count += 1.
  - Miss address (cpu_A with [1:0] cleared) is latched.
- MISS_WAIT:
  - stall=1, mem_A = latched address, mem_WE=0.
  - Counter decrements each cycle; at 0, next state is FILL.
- FILL:
  - stall=1, mem_A = latched address.
  - At the edge: line data ← mem_RD, tag written, valid ← 1, replay flag ← 1, next state IDLE.
- Replay flag is cleared on any IDLE cycle. The replayed access therefore hits without incrementing hit_count.
- mem_WE is 0 outside IDLE. The pipeline holds cpu_* stable while stall=1, and cpu_* are ignored outside IDLE.
- IDLE with no request: mem_A=cpu_A, mem_WD=cpu_WD, mem_WE=0, stall=0.
- cpu_RD is 0 when not serving a hit.
- Counters wrap at 2^32.

## Timing

- Reset (rst_n low, asynchronous):
  - State IDLE, all valid bits 0, wait counter 0, replay 0.
  - hit_count=0, miss_count=0.
  - Forced outputs while low: stall=0, mem_WE=0, cpu_RD=0, mem_A=0, mem_WD=0.
- Read hit: zero latency; data valid in the same cycle as cpu_RE.
- Read miss: stall high for exactly MISS_PENALTY+2 cycles (detect, MISS_PENALTY waits, FILL). Data is returned in the following IDLE cycle.
- Store: single cycle, never stalls; data memory is written at the same edge as the cache line.
- Reset mid-miss: FSM returns to IDLE and the in-flight line is not filled (valid stays 0). stall drops immediately (asynchronous).
- Aliasing: two addresses with the same index and different tags evict each other on read. A store to a non-resident tag does not evict.

## Test plan

- Reset, then load from 0x00010000 → stall high 6 cycles (MISS_PENALTY=4), data equals memory content; miss_count=1, hit_count=0.
- Repeat the same load on the next request → stall=0, same data, hit_count=1.
- Store 0xDEADBEEF to resident 0x00010000, then load → mem_WE=1 for one cycle, load hits and returns 0xDEADBEEF, no stall.
- Store 0x12345678 to non-resident 0x00010400, then load 0x00010400 → store has no stall; load misses (miss_count +1) and returns 0x12345678.
- Load 0x00010000, then 0x00010400 (same index), then 0x00010000 → three misses; miss_count=3, hit_count=0.
- Assert rst_n low during the 3rd MISS_WAIT cycle → stall=0 immediately, counters 0; the following load of the same address misses again.
